bubble_page_receiver: RTL and testbench

Host-side receiver for the two-line bubble data stream produced by the bubble interface (`bubble_out_odd` / `bubble_out_even`, qualified by `data_out_strobe`). It samples one odd/even bit pair per strobe and assembles pairs into bytes. It emits one addressed byte write per completed byte and flags page completion or a stalled stream. It sits on the motherboard/test side of the bubble data interface and is the consumer counterpart of the page-output path.

---
 rtl/bubble_page_receiver_if.sv | 36 +++
 rtl/bubble_page_receiver.sv | 124 ++++++++++++
 tb/tb_bubble_page_receiver.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bubble_page_receiver_if.sv
// bubble_page_receiver_if: bubble data stream in, addressed byte writes and page status out.
// BUBBLE_RX_CHECKSUM_EN adds the page_checksum signal.
interface bubble_page_receiver_if #(
  parameter int ADDR_W = 7
);
  logic capture_enable;
  logic data_out_strobe;
  logic bubble_in_odd;
  logic bubble_in_even;
  logic byte_valid;
  logic [7:0] byte_data;
  logic [ADDR_W-1:0] byte_address;
  logic page_done;
  logic timeout_error;
  logic busy;
`ifdef BUBBLE_RX_CHECKSUM_EN
  logic [15:0] page_checksum;
  modport master (
    output capture_enable, data_out_strobe, bubble_in_odd, bubble_in_even,
    input byte_valid, byte_data, byte_address, page_done, timeout_error, busy, page_checksum
  );
  modport slave (
    input capture_enable, data_out_strobe, bubble_in_odd, bubble_in_even,
    output byte_valid, byte_data, byte_address, page_done, timeout_error, busy, page_checksum
  );
`else
  modport master (
    output capture_enable, data_out_strobe, bubble_in_odd, bubble_in_even,
    input byte_valid, byte_data, byte_address, page_done, timeout_error, busy
  );
  modport slave (
    input capture_enable, data_out_strobe, bubble_in_odd, bubble_in_even,
    output byte_valid, byte_data, byte_address, page_done, timeout_error, busy
  );
`endif
endinterface

// File: rtl/bubble_page_receiver.sv
// bubble_page_receiver: assembles odd/even bubble bit pairs into addressed page bytes.
// BUBBLE_RX_CHECKSUM_EN adds a running 16-bit page checksum output.
module bubble_page_receiver #(
  parameter int PAGE_BYTES = 64,
  parameter int ADDR_W = 7,
  parameter int TIMEOUT = 1023
) (
  input logic master_clock,
  input logic master_reset,
  bubble_page_receiver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] shift_q, shift_d, byte_data_q, byte_data_d, next_shift;
  logic [1:0] pair_q, pair_d;
  logic [ADDR_W-1:0] idx_q, idx_d, byte_address_q, byte_address_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic byte_valid_q, byte_valid_d, page_done_q, page_done_d;
  logic timeout_error_q, timeout_error_d, busy_q, busy_d;
  logic last_pair, last_byte;
`ifdef BUBBLE_RX_CHECKSUM_EN
  logic [15:0] page_checksum_q, page_checksum_d;
  assign bus.page_checksum = page_checksum_q;
`endif
  assign next_shift = {shift_q[5:0], bus.bubble_in_odd, bus.bubble_in_even};
  assign last_pair = pair_q == 2'd3;
  assign last_byte = idx_q == ADDR_W'(PAGE_BYTES - 1);
  assign cnt_inc = cnt_q + 16'd1;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pair_d = pair_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    byte_valid_d = 1'b0;
    page_done_d = 1'b0;
    byte_data_d = byte_data_q;
    byte_address_d = byte_address_q;
    timeout_error_d = timeout_error_q;
`ifdef BUBBLE_RX_CHECKSUM_EN
    page_checksum_d = page_checksum_q;
`endif
    case (state_q)
      IDLE: if (bus.capture_enable) begin
        state_d = ARMED;
        pair_d = 2'd0;
        idx_d = '0;
        cnt_d = 16'd0;
        timeout_error_d = 1'b0;
`ifdef BUBBLE_RX_CHECKSUM_EN
        page_checksum_d = 16'd0;
`endif
      end
      ARMED, SHIFT: if (!bus.capture_enable) state_d = IDLE;
      else if (bus.data_out_strobe) begin
        // a strobe always beats a coincident timeout expiry
        state_d = SHIFT;
        shift_d = next_shift;
        pair_d = pair_q + 2'd1;
        cnt_d = 16'd0;
        if (last_pair) begin
          byte_valid_d = 1'b1;
          byte_data_d = next_shift;
          byte_address_d = idx_q;
          idx_d = idx_q + ADDR_W'(1);
`ifdef BUBBLE_RX_CHECKSUM_EN
          page_checksum_d = page_checksum_q + 16'(next_shift);
`endif
          if (last_byte) begin
            page_done_d = 1'b1;
            state_d = DONE;
          end
        end
      end else if (state_q == SHIFT) begin
        cnt_d = cnt_inc;
        if (cnt_inc == 16'(TIMEOUT)) begin
          timeout_error_d = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: if (!bus.capture_enable) state_d = IDLE;
    endcase
    busy_d = state_d == ARMED || state_d == SHIFT;
  end
  always_ff @(posedge master_clock) begin
    if (master_reset) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      pair_q <= 2'd0;
      idx_q <= '0;
      cnt_q <= 16'd0;
      byte_valid_q <= 1'b0;
      page_done_q <= 1'b0;
      byte_data_q <= 8'h00;
      byte_address_q <= '0;
      timeout_error_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef BUBBLE_RX_CHECKSUM_EN
      page_checksum_q <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pair_q <= pair_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      byte_valid_q <= byte_valid_d;
      page_done_q <= page_done_d;
      byte_data_q <= byte_data_d;
      byte_address_q <= byte_address_d;
      timeout_error_q <= timeout_error_d;
      busy_q <= busy_d;
`ifdef BUBBLE_RX_CHECKSUM_EN
      page_checksum_q <= page_checksum_d;
`endif
    end
  end
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data = byte_data_q;
  assign bus.byte_address = byte_address_q;
  assign bus.page_done = page_done_q;
  assign bus.timeout_error = timeout_error_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_bubble_page_receiver.sv
// tb_bubble_page_receiver: directed stimulus, page-level reference model checked every cycle.
// Define BUBBLE_RX_CHECKSUM_EN to also check page_checksum.
module tb_bubble_page_receiver;
  localparam int PAGE = 64;
  localparam int TMO = 1023;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bubble_page_receiver_if #(.ADDR_W(7)) bus();
  bubble_page_receiver #(.PAGE_BYTES(PAGE), .ADDR_W(7), .TIMEOUT(TMO)) dut (
    .master_clock(clk),
    .master_reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int ncheck = 0;
  int npass = 0;
  int nvalid = 0;
  int ndone = 0;
  logic [7:0] last_data = 8'h00;
  logic [6:0] last_addr = 7'd0;
  logic [6:0] done_addr = 7'd0;
  logic [15:0] done_cs = 16'd0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  bit active = 0, done = 0;
  int pairs = 0, quiet = 0, acc = 0;
  logic e_valid = 0, e_done = 0, e_terr = 0, e_busy = 0;
  logic [7:0] e_data = 0;
  logic [6:0] e_addr = 0;
  logic [15:0] e_cs = 0;
  // Model works in terms of pairs received this page and idle cycles since the last one.
  always begin
    @(posedge clk);
    e_valid = 0;
    e_done = 0;
    if (rst) begin
      active = 0; done = 0; pairs = 0; quiet = 0; acc = 0;
      e_data = 0; e_addr = 0; e_terr = 0; e_cs = 0;
    end else if (done) begin
      if (!bus.capture_enable) done = 0;
    end else if (!active) begin
      if (bus.capture_enable) begin
        active = 1; pairs = 0; quiet = 0; acc = 0; e_terr = 0; e_cs = 0;
      end
    end else if (!bus.capture_enable) active = 0;
    else if (bus.data_out_strobe) begin
      acc = (acc * 4 + int'(bus.bubble_in_odd) * 2 + int'(bus.bubble_in_even)) % 256;
      pairs++;
      quiet = 0;
      if (pairs % 4 == 0) begin
        e_valid = 1;
        e_data = 8'(acc);
        e_addr = 7'(pairs / 4 - 1);
        e_cs = 16'((int'(e_cs) + acc) % 65536);
        if (pairs / 4 == PAGE) begin
          e_done = 1; active = 0; done = 1;
        end
      end
    end else if (pairs > 0) begin
      quiet++;
      if (quiet == TMO) begin
        e_terr = 1; active = 0;
      end
    end
    e_busy = active;
    #1;
    check("byte_valid", bus.byte_valid, e_valid);
    check("byte_data", bus.byte_data, e_data);
    check("byte_address", bus.byte_address, e_addr);
    check("page_done", bus.page_done, e_done);
    check("timeout_error", bus.timeout_error, e_terr);
    check("busy", bus.busy, e_busy);
`ifdef BUBBLE_RX_CHECKSUM_EN
    check("page_checksum", bus.page_checksum, e_cs);
`endif
    if (bus.byte_valid === 1'b1) begin
      nvalid++;
      last_data = bus.byte_data;
      last_addr = bus.byte_address;
    end
    if (bus.page_done === 1'b1) begin
      ndone++;
      done_addr = bus.byte_address;
`ifdef BUBBLE_RX_CHECKSUM_EN
      done_cs = bus.page_checksum;
`endif
    end
  end
  task automatic send_pair(input logic o, input logic e, input int gap);
    bus.data_out_strobe = 1'b1;
    bus.bubble_in_odd = o;
    bus.bubble_in_even = e;
    @(negedge clk);
    bus.data_out_strobe = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 3; i >= 0; i--) send_pair(b[2*i+1], b[2*i], gap);
  endtask
  initial begin
    int k, v0, d0;
    bus.capture_enable = 1'b0;
    bus.data_out_strobe = 1'b0;
    bus.bubble_in_odd = 1'b0;
    bus.bubble_in_even = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", bus.byte_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_addr", bus.byte_address, 0);
    rst = 1'b0;
    @(negedge clk);
    // full page of 0xAA, with a strobe in the arming cycle that must be ignored
    bus.capture_enable = 1'b1;
    send_pair(1'b1, 1'b1, 0);
    check("armed_busy", bus.busy, 1);
    repeat (256) send_pair(1'b1, 1'b0, 0);
    check("page_done_pulse", bus.page_done, 1);
    check("page_done_addr", bus.byte_address, 63);
    repeat (3) send_pair(1'b1, 1'b1, 0);
    check("page_bytes", nvalid, 64);
    check("page_last_data", last_data, 8'hAA);
    check("page_done_count", ndone, 1);
    // sparse strobes, one byte 0xC6
    bus.capture_enable = 1'b0;
    repeat (2) @(negedge clk);
    bus.capture_enable = 1'b1;
    @(negedge clk);
    send_pair(1'b1, 1'b1, 3);
    send_pair(1'b0, 1'b0, 3);
    send_pair(1'b0, 1'b1, 3);
    bus.data_out_strobe = 1'b1;
    bus.bubble_in_odd = 1'b1;
    bus.bubble_in_even = 1'b0;
    @(negedge clk);
    bus.data_out_strobe = 1'b0;
    check("c6_valid", bus.byte_valid, 1);
    check("c6_data", bus.byte_data, 8'hC6);
    check("c6_addr", bus.byte_address, 0);
    @(negedge clk);
    check("c6_pulse_width", bus.byte_valid, 0);
    // timeout after the tenth pair
    repeat (6) send_pair(1'b0, 1'b1, 0);
    k = 0;
    while (bus.timeout_error !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycle", k, TMO);
    check("timeout_busy", bus.busy, 0);
    check("timeout_no_done", ndone, 1);
    @(negedge clk);
    check("rearm_clears_timeout", bus.timeout_error, 0);
    check("rearm_busy", bus.busy, 1);
    // abort after 130 pairs, coincident strobe discarded
    v0 = nvalid;
    d0 = ndone;
    for (int b = 0; b < 32; b++) send_byte(8'(b), 0);
    send_pair(1'b1, 1'b1, 0);
    send_pair(1'b0, 1'b1, 0);
    bus.capture_enable = 1'b0;
    bus.data_out_strobe = 1'b1;
    @(negedge clk);
    bus.data_out_strobe = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_bytes", nvalid - v0, 32);
    check("abort_no_done", ndone - d0, 0);
    // re-armed page of 0x00..0x3F
    @(negedge clk);
    bus.capture_enable = 1'b1;
    @(negedge clk);
    v0 = nvalid;
    send_byte(8'h00, 0);
    check("restart_addr", last_addr, 0);
    for (int b = 1; b < 64; b++) send_byte(8'(b), 0);
    check("ramp_bytes", nvalid - v0, 64);
    check("ramp_done", ndone - d0, 1);
    check("ramp_done_addr", done_addr, 63);
    check("ramp_last_data", last_data, 8'h3F);
`ifdef BUBBLE_RX_CHECKSUM_EN
    check("ramp_checksum", done_cs, 16'h07E0);
`endif
    // reset while in DONE
    rst = 1'b1;
    @(negedge clk);
    check("rst_done_data", bus.byte_data, 0);
    check("rst_done_addr", bus.byte_address, 0);
    check("rst_done_busy", bus.busy, 0);
    rst = 1'b0;
    bus.capture_enable = 1'b0;
    @(negedge clk);
    // reset on what would be a byte-completing strobe
    bus.capture_enable = 1'b1;
    @(negedge clk);
    repeat (3) send_pair(1'b1, 1'b0, 0);
    rst = 1'b1;
    bus.data_out_strobe = 1'b1;
    @(negedge clk);
    bus.data_out_strobe = 1'b0;
    check("rst_mid_valid", bus.byte_valid, 0);
    check("rst_mid_busy", bus.busy, 0);
    rst = 1'b0;
    bus.capture_enable = 1'b0;
    // strobes while idle
    v0 = nvalid;
    repeat (8) send_pair(1'b1, 1'b0, 0);
    @(negedge clk);
    check("idle_strobes", nvalid - v0, 0);
    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end
endmodule
